// File: rtl/bsg_tag_frame_decoder.sv
// bsg_tag_frame_decoder
//   Serial-to-parallel receiver for the bsg_tag bitstream (valid & data line).
//   Each frame is a start bit of 1, then id (id_w bits), data_not_reset
//   (1 bit), len (lg_width_p bits) and len payload bits. All fields arrive
//   LSB first. A completed frame is presented once over a valid/ready port.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          asynchronous active-high reset
//   en_i             bit-accept enable; all state holds while low
//   data_i           serial tag bit, sampled when en_i=1
//   v_o / ready_i    output frame handshake (transfer on v_o & ready_i)
//   client_id_o      frame client id
//   data_not_reset_o frame data_not_reset bit
//   len_o            frame payload length
//   payload_o        payload, bit k = k-th payload bit, bits >= len_o are 0
//   err_o            one-cycle pulse when an over-length frame is discarded
//   overflow_o       sticky, set when a completed frame finds the output busy
module bsg_tag_frame_decoder #(
  parameter int els_p               = 3,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 10,
  localparam int id_w               = (els_p <= 1) ? 1 : $clog2(els_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           en_i,
  input  logic                           data_i,
  output logic                           v_o,
  input  logic                           ready_i,
  output logic [id_w-1:0]                client_id_o,
  output logic                           data_not_reset_o,
  output logic [lg_width_p-1:0]          len_o,
  output logic [max_payload_width_p-1:0] payload_o,
  output logic                           err_o,
  output logic                           overflow_o
);

  // The field counter must cover both the id and the length/payload fields.
  localparam int cnt_w = (lg_width_p >= id_w) ? lg_width_p : id_w;

  typedef enum logic [2:0] {
    IDLE,
    ID,
    DNR,
    LEN,
    PAY
  } state_t;

  state_t                         state;
  logic [cnt_w-1:0]               cnt;
  logic [id_w-1:0]                id_r;
  logic                           dnr_r;
  logic [lg_width_p-1:0]          len_r;
  logic [max_payload_width_p-1:0] pay_r;
  logic                           over_r;

  // Field values including the bit being accepted this cycle.
  logic [id_w-1:0]                id_next;
  logic [lg_width_p-1:0]          len_next;
  logic [max_payload_width_p-1:0] pay_next;

  logic id_last;
  logic len_last;
  logic pay_last;
  logic len_over;
  logic done;

  always_comb begin
    id_next  = id_r;
    len_next = len_r;
    pay_next = pay_r;
    for (int unsigned k = 0; k < id_w; k++) begin
      if (state == ID && cnt == cnt_w'(k)) id_next[k] = data_i;
    end
    for (int unsigned k = 0; k < lg_width_p; k++) begin
      if (state == LEN && cnt == cnt_w'(k)) len_next[k] = data_i;
    end
    // Over-length payload bits are consumed but never stored.
    for (int unsigned k = 0; k < max_payload_width_p; k++) begin
      if (state == PAY && !over_r && cnt == cnt_w'(k)) pay_next[k] = data_i;
    end
  end

  assign id_last  = (cnt == cnt_w'(id_w - 1));
  assign len_last = (cnt == cnt_w'(lg_width_p - 1));
  // len_r is never 0 in PAY, so len_r-1 cannot underflow.
  assign pay_last = (cnt == cnt_w'(len_r) - cnt_w'(1));
  assign len_over = (32'(len_next) > 32'(max_payload_width_p));

  assign done = en_i && (((state == LEN) && len_last && (len_next == '0)) ||
                         ((state == PAY) && pay_last));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state            <= IDLE;
      cnt              <= '0;
      id_r             <= '0;
      dnr_r            <= 1'b0;
      len_r            <= '0;
      pay_r            <= '0;
      over_r           <= 1'b0;
      v_o              <= 1'b0;
      client_id_o      <= '0;
      data_not_reset_o <= 1'b0;
      len_o            <= '0;
      payload_o        <= '0;
      err_o            <= 1'b0;
      overflow_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (v_o && ready_i) v_o <= 1'b0;

      if (en_i) begin
        unique case (state)
          IDLE: begin
            if (data_i) begin
              state  <= ID;
              cnt    <= '0;
              pay_r  <= '0;
              over_r <= 1'b0;
            end
          end
          ID: begin
            id_r <= id_next;
            if (id_last) begin
              state <= DNR;
              cnt   <= '0;
            end else begin
              cnt <= cnt + cnt_w'(1);
            end
          end
          DNR: begin
            dnr_r <= data_i;
            state <= LEN;
            cnt   <= '0;
          end
          LEN: begin
            len_r <= len_next;
            if (len_last) begin
              cnt    <= '0;
              over_r <= len_over;
              state  <= (len_next == '0) ? IDLE : PAY;
            end else begin
              cnt <= cnt + cnt_w'(1);
            end
          end
          PAY: begin
            pay_r <= pay_next;
            if (pay_last) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + cnt_w'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end

      // Completion: a handshake in the same cycle frees the single output
      // slot, so the new frame may load while v_o stays high.
      if (done) begin
        if (state == PAY && over_r) begin
          err_o <= 1'b1;
        end else if (!v_o || ready_i) begin
          v_o              <= 1'b1;
          client_id_o      <= id_r;
          data_not_reset_o <= dnr_r;
          len_o            <= len_next;
          payload_o        <= pay_next;
        end else begin
          overflow_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bsg_tag_frame_decoder.sv
// Self-checking bench for bsg_tag_frame_decoder: frames are built from
// field values, expected records are queued when a frame is sent and
// compared when the decoder presents a new frame.
module tb_bsg_tag_frame_decoder;

  localparam int ELS  = 3;
  localparam int LGW  = 4;
  localparam int MAXP = 10;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            en_i;
  logic            data_i;
  logic            ready_i;
  logic            v_o;
  logic [IDW-1:0]  client_id_o;
  logic            data_not_reset_o;
  logic [LGW-1:0]  len_o;
  logic [MAXP-1:0] payload_o;
  logic            err_o;
  logic            overflow_o;

  bsg_tag_frame_decoder #(
    .els_p              (ELS),
    .lg_width_p         (LGW),
    .max_payload_width_p(MAXP)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .en_i            (en_i),
    .data_i          (data_i),
    .v_o             (v_o),
    .ready_i         (ready_i),
    .client_id_o     (client_id_o),
    .data_not_reset_o(data_not_reset_o),
    .len_o           (len_o),
    .payload_o       (payload_o),
    .err_o           (err_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int dnr;
    int len;
    int pay;
  } frame_t;

  frame_t sb[$];
  frame_t held;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     err_seen = 0;
  int     err_exp  = 0;
  logic   fbits[0:39];
  int     fn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic drive_bit(input logic en, input logic b);
    en_i   = en;
    data_i = b;
    @(posedge clk);
    #2;
  endtask

  task automatic build(input int id, input int dnr, input int len, input int pay);
    fn = 0;
    fbits[fn] = 1'b1; fn++;
    for (int i = 0; i < IDW; i++) begin fbits[fn] = id[i]; fn++; end
    fbits[fn] = dnr[0]; fn++;
    for (int i = 0; i < LGW; i++) begin fbits[fn] = len[i]; fn++; end
    for (int i = 0; i < len; i++) begin fbits[fn] = pay[i]; fn++; end
  endtask

  task automatic send_frame(input int id, input int dnr, input int len, input int pay,
                            input bit gaps, input bit rdy_last, input bit push);
    frame_t e;
    build(id, dnr, len, pay);
    if (len > MAXP) begin
      err_exp++;
    end else if (push) begin
      e.id  = id;
      e.dnr = dnr;
      e.len = len;
      e.pay = pay & ((1 << len) - 1);
      sb.push_back(e);
    end
    for (int i = 0; i < fn; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive_bit(1'b0, 1'($urandom));
      if (rdy_last && i == fn - 1) ready_i = 1'b1;
      drive_bit(1'b1, fbits[i]);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) drive_bit(1'b1, 1'b0);
  endtask

  // Monitor: a new frame is v_o rising, or v_o held high across a handshake.
  initial begin : monitor
    logic   v_prev;
    logic   hs_prev;
    frame_t e;
    v_prev  = 1'b0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        v_prev  = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (err_o) err_seen++;
        if (v_o) begin
          if (!v_prev || hs_prev) begin
            if (sb.size() == 0) begin
              check("unexpected_frame", 32'(v_o), 32'd0);
            end else begin
              e = sb.pop_front();
              check("client_id", 32'(client_id_o), 32'(e.id));
              check("dnr", 32'(data_not_reset_o), 32'(e.dnr));
              check("len", 32'(len_o), 32'(e.len));
              check("payload", 32'(payload_o), 32'(e.pay));
              held = e;
            end
          end else if (!hs_prev) begin
            check("hold_id", 32'(client_id_o), 32'(held.id));
            check("hold_payload", 32'(payload_o), 32'(held.pay));
          end
        end
        hs_prev = v_o && ready_i;
        v_prev  = v_o;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1;
    en_i    = 1'b0;
    data_i  = 1'b0;
    ready_i = 1'b0;
    #3;
    check("rst_v", 32'(v_o), 32'd0);
    check("rst_payload", 32'(payload_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(posedge clk); #2;
    reset_i = 1'b0;
    idle_cycles(2);

    // Basic frame, held until ready.
    send_frame(2, 1, 7, 'h5A, 1'b0, 1'b0, 1'b1);
    check("basic_lat_v", 32'(v_o), 32'd1);
    check("basic_payload_lit", 32'(payload_o), 32'h05A);
    check("basic_id_lit", 32'(client_id_o), 32'd2);
    idle_cycles(3);
    check("basic_hold_v", 32'(v_o), 32'd1);
    ready_i = 1'b1;
    idle_cycles(1);
    check("basic_drop_v", 32'(v_o), 32'd0);
    ready_i = 1'b0;

    // Zero-length frame.
    send_frame(1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("zero_lat_v", 32'(v_o), 32'd1);
    check("zero_len", 32'(len_o), 32'd0);
    check("zero_payload", 32'(payload_o), 32'd0);
    ready_i = 1'b1;
    idle_cycles(1);

    // Over-length frame followed back-to-back by a valid one.
    send_frame(0, 1, 12, int'($urandom_range(0, 4095)), 1'b0, 1'b0, 1'b0);
    check("over_err", 32'(err_o), 32'd1);
    check("over_v", 32'(v_o), 32'd0);
    send_frame(2, 0, 10, 'h3FF, 1'b0, 1'b0, 1'b1);
    check("after_over_err", 32'(err_o), 32'd0);
    idle_cycles(2);

    // Overflow with output held.
    ready_i = 1'b0;
    send_frame(1, 1, 3, 'h5, 1'b0, 1'b0, 1'b1);
    send_frame(2, 0, 4, 'hA, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_v", 32'(v_o), 32'd1);
    check("ovf_held_id", 32'(client_id_o), 32'd1);
    ready_i = 1'b1;
    idle_cycles(1);
    check("ovf_consumed_v", 32'(v_o), 32'd0);
    ready_i = 1'b0;
    idle_cycles(3);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    en_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk); #2;
    reset_i = 1'b0;
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Same-cycle handshake lets the second frame load.
    send_frame(0, 1, 2, 'h2, 1'b0, 1'b0, 1'b1);
    send_frame(2, 1, 5, 'h13, 1'b0, 1'b1, 1'b1);
    check("hs_load_v", 32'(v_o), 32'd1);
    check("hs_no_ovf", 32'(overflow_o), 32'd0);
    check("hs_len", 32'(len_o), 32'd5);
    idle_cycles(1);
    check("hs_drain_v", 32'(v_o), 32'd0);

    // Enable gaps: same frames with and without idle en_i cycles.
    for (int i = 0; i < 6; i++) begin
      int id, dnr, len, pay;
      id  = int'($urandom_range(0, 2));
      dnr = int'($urandom_range(0, 1));
      len = int'($urandom_range(0, MAXP));
      pay = int'($urandom_range(0, 1023));
      send_frame(id, dnr, len, pay, 1'b0, 1'b0, 1'b1);
      send_frame(id, dnr, len, pay, 1'b1, 1'b0, 1'b1);
    end
    idle_cycles(2);

    // Reset mid-PAY while a frame is held.
    ready_i = 1'b0;
    send_frame(1, 0, 6, 'h2B, 1'b0, 1'b0, 1'b1);
    build(2, 1, 5, 'h1F);
    for (int i = 0; i < 10; i++) drive_bit(1'b1, fbits[i]);
    en_i = 1'b0;
    #1 reset_i = 1'b1;
    #1;
    check("midrst_v", 32'(v_o), 32'd0);
    check("midrst_id", 32'(client_id_o), 32'd0);
    check("midrst_dnr", 32'(data_not_reset_o), 32'd0);
    check("midrst_len", 32'(len_o), 32'd0);
    check("midrst_payload", 32'(payload_o), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    @(posedge clk); #2;
    reset_i = 1'b0;
    ready_i = 1'b1;
    send_frame(2, 1, 9, 'h1C3, 1'b0, 1'b0, 1'b1);
    check("postrst_v", 32'(v_o), 32'd1);
    idle_cycles(3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("err_count", 32'(err_seen), 32'(err_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
